axis_master: RTL and testbench

AXI-Stream transmitter: the sending end of the byte-wide stream interface our `axis_slave` receives. A host-side write port loads a local byte buffer. A start command then streams a contiguous, wrapping region of that buffer as one frame on TDATA/TVALID/TLAST, obeying TREADY back-pressure. Tdone pulses once the final beat is accepted. The block sits upstream of `axis_slave` and connects beat-for-beat.

---
 rtl/axis_master.sv | 128 ++++++++++++
 tb/tb_axis_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_master.sv
// AXI-Stream byte transmitter: a host-written local buffer is streamed as one
// wrapping frame on TDATA/TVALID/TLAST with TREADY back-pressure and a Tdone pulse.
module axis_master #(
  parameter int MEM_SIZE  = 256,
  parameter int AXI_WIDTH = 8,
  parameter int AW        = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [AXI_WIDTH-1:0] wr_data,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW:0]          length,
  output logic                 busy,
  output logic [AXI_WIDTH-1:0] TDATA,
  output logic                 TVALID,
  output logic                 TLAST,
  input  logic                 TREADY,
  output logic                 Tdone
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [AW:0] MEM_BEATS = (AW+1)'(MEM_SIZE);
  localparam logic [AW:0] REM_ONE   = (AW+1)'(1);
  localparam logic [AW:0] REM_TWO   = (AW+1)'(2);

  logic [AXI_WIDTH-1:0] mem [MEM_SIZE];

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW:0]          rem_q, rem_d;
  logic [AXI_WIDTH-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic                 tdone_q, tdone_d;

  logic [AW-1:0]        fetch_addr;
  logic [AXI_WIDTH-1:0] fetch_data;
  logic [AW:0]          len_clamped;
  logic [AW-1:0]        ptr_next;

  // Buffer is not reset; a same-cycle write to the fetched address yields old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign ptr_next    = ptr_q + AW'(1);
  assign fetch_addr  = (state_q == IDLE) ? start_addr : ptr_next;
  assign fetch_data  = mem[fetch_addr];
  assign len_clamped = (length > MEM_BEATS) ? MEM_BEATS : length;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdone_q  <= tdone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdone_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && (length != '0)) begin
          state_d  = SEND;
          ptr_d    = start_addr;
          rem_d    = len_clamped;
          tdata_d  = fetch_data;
          tvalid_d = 1'b1;
          tlast_d  = (len_clamped == REM_ONE);
        end
      end
      SEND: begin
        if (tvalid_q && TREADY) begin
          if (rem_q > REM_ONE) begin
            ptr_d   = ptr_next;
            tdata_d = fetch_data;
            rem_d   = rem_q - REM_ONE;
            tlast_d = (rem_q == REM_TWO);
          end else begin
            rem_d    = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdone_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign TDATA  = tdata_q;
  assign TVALID = tvalid_q;
  assign TLAST  = tlast_q;
  assign Tdone  = tdone_q;

endmodule

// File: tb/tb_axis_master.sv
// Directed self-checking bench for axis_master: framing, back-pressure, wrap,
// length edge cases, ignored starts, collisions and asynchronous reset.
module tb_axis_master;

  localparam int MEM_SIZE  = 256;
  localparam int AXI_WIDTH = 8;
  localparam int AW        = 8;

  logic                 clk;
  logic                 reset;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [AXI_WIDTH-1:0] wr_data;
  logic                 start;
  logic [AW-1:0]        start_addr;
  logic [AW:0]          length;
  logic                 busy;
  logic [AXI_WIDTH-1:0] TDATA;
  logic                 TVALID;
  logic                 TLAST;
  logic                 TREADY;
  logic                 Tdone;

  logic [7:0] model [MEM_SIZE];
  int n_checks;
  int n_errors;

  axis_master #(.MEM_SIZE(MEM_SIZE), .AXI_WIDTH(AXI_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .TDATA      (TDATA),
    .TVALID     (TVALID),
    .TLAST      (TLAST),
    .TREADY     (TREADY),
    .Tdone      (Tdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tdata"},  32'(TDATA),  32'h0);
    check({tag, "_tvalid"}, 32'(TVALID), 32'h0);
    check({tag, "_tlast"},  32'(TLAST),  32'h0);
    check({tag, "_tdone"},  32'(Tdone),  32'h0);
    check({tag, "_busy"},   32'(busy),   32'h0);
  endtask

  // All driving happens at negedge; each task returns at a negedge.
  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = AXI_WIDTH'(d);
    @(negedge clk);
    wr_en   = 1'b0;
    model[a % MEM_SIZE] = 8'(d);
  endtask

  task automatic do_start(input int a, input int len);
    start      = 1'b1;
    start_addr = AW'(a);
    length     = (AW+1)'(len);
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Consume one frame of n beats from base, driving TREADY from a cyclic pattern.
  task automatic stream(input int n, input int base, input logic [15:0] pat,
                        input int plen, input int exp_cyc, input bit inject);
    int   got;
    int   k;
    int   cyc;
    bit   done;
    logic pv, pr, pl;
    logic [7:0] pd;
    got = 0; k = 0; cyc = 0; done = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
    check("first_valid", 32'(TVALID), 32'h1);
    while (!done && cyc < 3000) begin
      if (pv && !pr)
        check("hold", {22'h0, TVALID, TLAST, TDATA}, {22'h0, pv, pl, pd});
      if (TVALID)
        check("tlast_pos", 32'(TLAST), 32'(got == n - 1));
      else
        check("tlast_novalid", 32'(TLAST), 32'h0);
      if (inject && k == 1) begin
        start = 1'b1; start_addr = 8'd254; length = 9'd3;
      end else begin
        start = 1'b0;
      end
      TREADY = pat[k % plen];
      k++;
      if (TVALID && TREADY) begin
        check("beat_data", 32'(TDATA), 32'(model[(base + got) % MEM_SIZE]));
        got++;
        if (got == n) done = 1;
      end
      pv = TVALID; pr = TREADY; pl = TLAST; pd = TDATA;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("beats", 32'(got), 32'(n));
    check("frame_cycles", 32'(cyc), 32'(exp_cyc));
    check("tdone_pulse", 32'(Tdone), 32'h1);
    check("busy_in_done", 32'(busy), 32'h1);
    check("tvalid_off", 32'(TVALID), 32'h0);
    if (inject) begin
      start = 1'b1; start_addr = 8'd254; length = 9'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check("tdone_clear", 32'(Tdone), 32'h0);
    check("busy_idle", 32'(busy), 32'h0);
    check("no_queued_valid", 32'(TVALID), 32'h0);
    TREADY = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; length = '0; TREADY = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < MEM_SIZE; i++) wr(i, (i * 7 + 3) & 255);
    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);

    // Basic 4-beat frame, always ready.
    do_start(0, 4);
    stream(4, 0, 16'h1, 1, 4, 0);

    // Back-pressure: TREADY 1,0,0,1,0,1,1.
    do_start(0, 4);
    stream(4, 0, 16'h0069, 7, 7, 0);

    // Starts during SEND and DONE must be ignored.
    do_start(0, 4);
    stream(4, 0, 16'h1, 1, 4, 1);

    // Zero length is ignored.
    do_start(0, 0);
    for (int i = 0; i < 3; i++) begin
      check("len0_tvalid", 32'(TVALID), 32'h0);
      check("len0_busy", 32'(busy), 32'h0);
      @(negedge clk);
    end

    // Single-beat frame.
    wr(5, 8'h5A);
    do_start(5, 1);
    check("len1_tlast", 32'(TLAST), 32'h1);
    stream(1, 5, 16'h1, 1, 1, 0);

    // Write and fetch of the same address in one cycle return the old byte.
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hC3;
    do_start(5, 1);
    wr_en = 1'b0;
    check("collide_old", 32'(TDATA), 32'h5A);
    stream(1, 5, 16'h1, 1, 1, 0);
    model[5] = 8'hC3;
    do_start(5, 1);
    check("collide_new", 32'(TDATA), 32'hC3);
    stream(1, 5, 16'h1, 1, 1, 0);

    // Wrap from the top of the buffer.
    wr(254, 8'hA0); wr(255, 8'hA1); wr(0, 8'hA2);
    do_start(254, 3);
    stream(3, 254, 16'h1, 1, 3, 0);

    // Over-long request clamps to the buffer depth.
    do_start(10, 300);
    stream(256, 10, 16'h1, 1, 256, 0);

    // Asynchronous reset during beat 2 of 4.
    do_start(0, 4);
    check("rst_beat1", 32'(TDATA), 32'(model[0]));
    @(negedge clk);
    check("rst_beat2", 32'(TDATA), 32'(model[1]));
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_tdone", 32'(Tdone), 32'h0);
      check("post_rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
    end
    do_start(0, 4);
    stream(4, 0, 16'h1, 1, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
